// File: rtl/red_nibble_seq_pkg.sv
// Shared definitions for the packed-nibble reduction unit:
// state encoding, lane count and the nibble sign-extension helper.
package red_nibble_seq_pkg;

  localparam int NIBBLES = 4;
  localparam int SEXT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [SEXT_W-1:0] sext_nib(input logic [3:0] n);
    return {{(SEXT_W-4){n[3]}}, n};
  endfunction

endpackage

// File: rtl/red_nibble_seq_lane.sv
// Single narrow adder: accumulator plus the sign-extended nibbles of lane sel_i
// taken from both packed operands.
module nibble_lane_add
  import red_nibble_seq_pkg::*;
(
  input  logic [SEXT_W-1:0]    acc_i,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  input  logic [1:0]           sel_i,
  output logic [SEXT_W-1:0]    sum_o
);

  logic [3:0] a_nib;
  logic [3:0] b_nib;

  always_comb begin
    a_nib = a_i[4*sel_i +: 4];
    b_nib = b_i[4*sel_i +: 4];
    sum_o = acc_i + sext_nib(a_nib) + sext_nib(b_nib);
  end

endmodule

// File: rtl/red_nibble_seq.sv
// Sequential reduction of eight signed nibbles (four per operand) through one
// lane adder, one lane per cycle, with a start/busy/done handshake.
module red_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Result
);
  import red_nibble_seq_pkg::*;

  localparam logic [1:0] LAST_LANE = 2'(NIBBLES - 1);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [SEXT_W-1:0] acc_q;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic [15:0]       result_q;
  logic [SEXT_W-1:0] sum_d;

  nibble_lane_add u_lane (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .sel_i (cnt_q),
    .sum_o (sum_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      acc_q    <= '0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts start too, giving back-to-back operation
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= 2'd0;
            acc_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST_LANE) begin
            result_q <= {{(16-SEXT_W){sum_d[SEXT_W-1]}}, sum_d};
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_red_nibble_seq.sv
// Self-checking bench: cycle-timeline reference model plus directed scenarios
// and a randomized start/operand stream.
module tb_red_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] Result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  red_nibble_seq #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sum of the eight signed nibbles, as a 16-bit two's complement word
  function automatic logic [15:0] nib_sum(input logic [15:0] a, input logic [15:0] b);
    int s;
    int n;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      n = int'(a[4*i +: 4]); if (n > 7) n -= 16; s += n;
      n = int'(b[4*i +: 4]); if (n > 7) n -= 16; s += n;
    end
    return 16'(s);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: an accepted start makes busy high for 4 cycles, then done
  // for one cycle with the new result; start counts only when not busy.
  int          m_busy_left = 0;
  bit          m_done = 0;
  logic [15:0] m_result = 16'h0000;
  logic [15:0] m_pending = 16'h0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_left = 0;
      m_done      = 0;
      m_result    = 16'h0000;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_done   = 1;
        m_result = m_pending;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_busy_left = 4;
        m_pending   = nib_sum(A, B);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("model_busy",   16'(busy), 16'(m_busy_left > 0));
      chk("model_done",   16'(done), 16'(m_done));
      chk("model_result", Result, m_result);
    end
  end

  task automatic wait_done(output bit ok, output int busy_cycles);
    ok = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input string name);
    int c0;
    int bc;
    bit ok;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    wait_done(ok, bc);
    if (ok) begin
      chk({name, "_latency"}, 16'(cyc - c0), 16'd4);
      chk({name, "_busy_cycles"}, 16'(bc), 16'd4);
      chk({name, "_result"}, Result, exp);
    end
  endtask

  initial begin
    int c0;
    int d1;
    int bc;
    bit ok;

    repeat (3) @(negedge clk);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_result", Result, 16'h0000);
    rst = 1'b0;

    // Pin the model against hand-computed sums
    chk("model_pin_a", nib_sum(16'h1234, 16'h0000), 16'h000A);
    chk("model_pin_b", nib_sum(16'h8888, 16'h8888), 16'hFFC0);

    do_op(16'h1234, 16'h0000, 16'h000A, "basic");
    do_op(16'h8888, 16'h8888, 16'hFFC0, "neg_extreme");
    do_op(16'h7777, 16'h7777, 16'h0038, "pos_extreme");
    do_op(16'hFFFF, 16'h0001, 16'hFFFD, "minus3");

    // start during RUN cycle 2 with a new A must be ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h0000; start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'h7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, bc);
    if (ok) begin
      chk("ignored_start_latency", 16'(cyc - c0), 16'd4);
      chk("ignored_start_result", Result, 16'h000A);
    end
    @(negedge clk);
    chk("ignored_start_no_queue", 16'(busy), 16'd0);

    // Back-to-back start in the DONE cycle
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, bc);
    d1 = cyc;
    A = 16'h8888; B = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok, bc);
    if (ok) begin
      chk("b2b_spacing", 16'(cyc - d1), 16'd5);
      chk("b2b_result", Result, 16'hFFE1);
    end

    // Reset during RUN cycle 2 aborts the operation
    @(negedge clk);
    A = 16'h7777; B = 16'h7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", Result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", 16'(done), 16'd0);
    end

    // Randomized stream checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      A = 16'($urandom);
      B = 16'($urandom);
      if ($urandom_range(0, 400) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
